// File: rtl/main_mem_arbiter_pkg.sv
// Shared memory-subsystem definitions: arbiter FSM encoding, requester port
// indices and the index-to-one-hot helper used by the grant logic.
package main_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam logic PORT_ICACHE = 1'b0;
  localparam logic PORT_DCACHE = 1'b1;

  function automatic logic [1:0] port_onehot(input logic idx);
    logic [1:0] oh;
    if (idx == PORT_DCACHE) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/main_mem_arbiter_rr_pick2.sv
// Two-way round-robin winner selection: on a tie the port that did not win
// last time is chosen; a lone requester always wins.
module rr_pick2
  import main_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       winner
);

  // Winner index and matching one-hot grant; no grant when nobody asks.
  always_comb begin
    winner = PORT_ICACHE;
    grant  = 2'b00;
    case (req)
      2'b01:   winner = PORT_ICACHE;
      2'b10:   winner = PORT_DCACHE;
      2'b11:   winner = ~last_grant;
      default: winner = PORT_ICACHE;
    endcase
    if (req != 2'b00) begin
      grant = port_onehot(winner);
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Arbitrates the icache and dcache ports onto a single main-memory controller,
// one transaction at a time, with round-robin fairness on contention.
module main_mem_arbiter
  import main_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req,
  input  logic              rd_wr0,
  input  logic              rd_wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_r;
  arb_state_e        state_next_s;
  logic              last_grant_r;
  logic [1:0]        grant_r;
  logic [1:0]        pick_grant_s;
  logic              pick_winner_s;
  logic              accept_s;
  logic              capture_s;
  logic [1:0]        ack_r;
  logic              busy_r;
  logic              mem_en_r;
  logic              mem_rd_wr_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] rdata_r;

  rr_pick2 u_rr_pick2 (
    .req        (req),
    .last_grant (last_grant_r),
    .grant      (pick_grant_s),
    .winner     (pick_winner_s)
  );

  // Requests are only looked at in IDLE; memory completion only in WAIT.
  assign accept_s  = (state_r == ST_IDLE) && (req != 2'b00);
  assign capture_s = (state_r == ST_WAIT) && mem_valid;

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (mem_valid) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Winner bookkeeping; last_grant resets to 1 so port 0 takes the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= 1'b1;
      grant_r      <= 2'b00;
    end else if (accept_s) begin
      last_grant_r <= pick_winner_s;
      grant_r      <= pick_grant_s;
    end
  end

  // Operands of the winner are frozen here from ISSUE through DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_rd_wr_r <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else if (accept_s) begin
      if (pick_winner_s == PORT_DCACHE) begin
        mem_rd_wr_r <= rd_wr1;
        mem_addr_r  <= addr1;
        mem_wdata_r <= wdata1;
      end else begin
        mem_rd_wr_r <= rd_wr0;
        mem_addr_r  <= addr0;
        mem_wdata_r <= wdata0;
      end
    end
  end

  // Read line capture; writes load it too and the requester ignores it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_r <= '0;
    end else if (capture_s) begin
      rdata_r <= mem_rdata;
    end
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_en_r <= 1'b0;
      busy_r   <= 1'b0;
      ack_r    <= 2'b00;
    end else begin
      mem_en_r <= (state_next_s == ST_ISSUE);
      busy_r   <= (state_next_s != ST_IDLE);
      if (state_next_s == ST_DONE) begin
        ack_r <= grant_r;
      end else begin
        ack_r <= 2'b00;
      end
    end
  end

  assign ack       = ack_r;
  assign busy      = busy_r;
  assign mem_en    = mem_en_r;
  assign mem_rd_wr = mem_rd_wr_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign rdata     = rdata_r;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter: a round-robin reference model pushes
// expected transactions to a scoreboard that is checked at each ack.
module tb_main_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

  logic              clk;
  logic              reset_n;
  logic [1:0]        req;
  logic              rd_wr0, rd_wr1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [1:0]        ack;
  logic [DATA_W-1:0] rdata;
  logic              busy, mem_en, mem_rd_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;

  typedef struct {
    logic              port;
    logic              rd_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic        tb_last;
  int          checks;
  int          errors;

  main_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .rd_wr0(rd_wr0), .rd_wr1(rd_wr1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"}, DATA_W'(ack), '0);
    chk({tag, "_busy"}, DATA_W'(busy), '0);
    chk({tag, "_mem_en"}, DATA_W'(mem_en), '0);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = 2'b00;
    mem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tb_last = 1'b1;
    sb.delete();
    @(negedge clk);
  endtask

  // One full transaction starting from a negedge in IDLE, ending at a negedge in IDLE.
  task automatic run_txn(input logic [1:0] req_v, input int waits, input logic [DATA_W-1:0] resp,
                         input logic [1:0] next_req, input bit toggle);
    exp_t e;
    exp_t got;
    if (req_v == 2'b11) e.port = ~tb_last;
    else                e.port = req_v[1];
    tb_last = e.port;
    e.rd_wr = e.port ? rd_wr1 : rd_wr0;
    e.addr  = e.port ? addr1  : addr0;
    e.wdata = e.port ? wdata1 : wdata0;
    e.rdata = resp;
    sb.push_back(e);
    req = req_v;
    @(negedge clk);  // ISSUE
    chk("issue_mem_en", DATA_W'(mem_en), DATA_W'(1'b1));
    chk("issue_busy", DATA_W'(busy), DATA_W'(1'b1));
    chk("issue_addr", DATA_W'(mem_addr), DATA_W'(e.addr));
    chk("issue_rd_wr", DATA_W'(mem_rd_wr), DATA_W'(e.rd_wr));
    chk("issue_wdata", mem_wdata, e.wdata);
    mem_valid = 1'b1;
    mem_rdata = ~resp;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);  // WAIT
      mem_valid = 1'b0;
      if (toggle) req = req ^ 2'b11;
      chk("wait_ack", DATA_W'(ack), '0);
      chk("wait_mem_en", DATA_W'(mem_en), '0);
      chk("wait_busy", DATA_W'(busy), DATA_W'(1'b1));
      chk("wait_addr", DATA_W'(mem_addr), DATA_W'(e.addr));
      chk("wait_wdata", mem_wdata, e.wdata);
    end
    req       = req_v;
    mem_valid = 1'b1;
    mem_rdata = resp;
    @(negedge clk);  // DONE
    mem_valid = 1'b0;
    mem_rdata = {4{$urandom}};
    got = sb.pop_front();
    chk("done_ack", DATA_W'(ack), DATA_W'(got.port ? 2'b10 : 2'b01));
    chk("done_rdata", rdata, got.rdata);
    chk("done_addr", DATA_W'(mem_addr), DATA_W'(got.addr));
    chk("done_rd_wr", DATA_W'(mem_rd_wr), DATA_W'(got.rd_wr));
    chk("done_wdata", mem_wdata, got.wdata);
    req = next_req;
    @(negedge clk);  // IDLE
    chk_idle_outputs("post_done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tb_last = 1'b1;
    reset_n = 1'b0;
    req = 2'b00;
    rd_wr0 = 1'b1; rd_wr1 = 1'b1;
    addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_rd_wr", DATA_W'(mem_rd_wr), '0);
    chk("reset_addr", DATA_W'(mem_addr), '0);
    chk("reset_wdata", mem_wdata, '0);
    chk("reset_rdata", rdata, '0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single icache read.
    rd_wr0 = 1'b1; addr0 = 32'h0000_0100;
    run_txn(2'b01, 3, {16{8'hA5}}, 2'b00, 1'b0);

    // Tie from reset followed by sustained contention: 0,1,0,1.
    do_reset();
    addr0 = 32'h0000_1000; wdata0 = {4{32'h1111_1111}};
    rd_wr1 = 1'b1; addr1 = 32'h0000_2000; wdata1 = {4{32'h2222_2222}};
    run_txn(2'b11, 1, {4{32'hC0DE_0001}}, 2'b11, 1'b0);
    run_txn(2'b11, 2, {4{32'hC0DE_0002}}, 2'b11, 1'b0);
    run_txn(2'b11, 1, {4{32'hC0DE_0003}}, 2'b11, 1'b0);
    run_txn(2'b11, 4, {4{32'hC0DE_0004}}, 2'b00, 1'b0);

    // dcache write with req toggling during WAIT.
    rd_wr1 = 1'b0; addr1 = 32'hFFFF_FFC0; wdata1 = {4{32'hDEAD_BEEF}};
    run_txn(2'b10, 3, {4{32'h1234_5678}}, 2'b00, 1'b1);

    // Spurious mem_valid while idle must not disturb anything.
    mem_valid = 1'b1;
    mem_rdata = {4{32'hBAD0_BAD0}};
    @(negedge clk);
    mem_valid = 1'b0;
    @(negedge clk);
    chk_idle_outputs("spurious");
    chk("spurious_rdata", rdata, {4{32'h1234_5678}});
    chk("spurious_addr", DATA_W'(mem_addr), DATA_W'(32'hFFFF_FFC0));
    chk("spurious_wdata", mem_wdata, {4{32'hDEAD_BEEF}});

    // Reset in WAIT abandons the transaction.
    rd_wr0 = 1'b1; addr0 = 32'h0000_0300;
    req = 2'b01;
    @(negedge clk);
    chk("rst_issue_mem_en", DATA_W'(mem_en), DATA_W'(1'b1));
    @(negedge clk);
    chk("rst_wait_busy", DATA_W'(busy), DATA_W'(1'b1));
    reset_n = 1'b0;
    req = 2'b00;
    mem_valid = 1'b1;
    mem_rdata = {4{32'h5555_AAAA}};
    #1;
    chk_idle_outputs("async_rst");
    chk("async_rst_rd_wr", DATA_W'(mem_rd_wr), '0);
    chk("async_rst_addr", DATA_W'(mem_addr), '0);
    chk("async_rst_wdata", mem_wdata, '0);
    chk("async_rst_rdata", rdata, '0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_valid = 1'b0;
    tb_last = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_rst");
    @(negedge clk);
    chk_idle_outputs("post_rst2");
    run_txn(2'b01, 2, {4{32'h0F0F_0F0F}}, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_mem_arbiter.md
MAIN_MEM_ARBITER -- requirements
Module: main_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request address width.
REQ-002 SHALL have parameter DATA_W, default 128, line data width (one cache line).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  2  per-port request; bit0 = icache, bit1 = dcache.
REQ-007 SHALL have port rd_wr0 / rd_wr1  input  1 each  1 = read, 0 = write.
REQ-008 SHALL have port addr0 / addr1  input  ADDR_W each  request address.
REQ-009 SHALL have port wdata0 / wdata1  input  DATA_W each  write line.
REQ-010 SHALL have port ack  output  2  one-cycle completion pulse, one-hot per port.
REQ-011 SHALL have port rdata  output  DATA_W  read line; valid only while ack is nonzero.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port mem_en  output  1  start pulse to the main memory controller.
REQ-014 SHALL have port mem_rd_wr  output  1  latched direction.
REQ-015 SHALL have port mem_addr  output  ADDR_W  latched address.
REQ-016 SHALL have port mem_wdata  output  DATA_W  latched write data.
REQ-017 SHALL have port mem_valid  input  1  completion strobe from the memory controller.
REQ-018 SHALL have port mem_rdata  input  DATA_W  read data, qualified by mem_valid.

Function
REQ-019 FSM SHALL have 4 states: IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE:
- req != 0: SHALL select a winner, latch its rd_wr/addr/wdata into the mem_* registers, record the winner, and go to ISSUE.
- req == 0: SHALL stay in IDLE.
REQ-021 ISSUE: SHALL assert mem_en for exactly this one cycle, then go to WAIT.
REQ-022 WAIT:
- mem_valid high: SHALL capture mem_rdata into the rdata register and go to DONE.
- mem_valid low: SHALL stay in WAIT, with no timeout.
REQ-023 DONE: SHALL assert ack[winner] for one cycle, then go to IDLE; the next request is accepted no earlier than the cycle after DONE.
REQ-024 Arbitration SHALL be round-robin using a last_grant bit:
- Both req bits set: the port not equal to last_grant wins.
- One req bit set: that port wins.
- last_grant SHALL update on every IDLE->ISSUE transition.
REQ-025 Minimum latency: req sampled in cycle N; mem_en in N+1; ack in cycle M+1, where M is the cycle mem_valid is sampled.
REQ-026 Requesters SHALL hold req and operands stable until ack; req bits SHALL be ignored outside IDLE.
REQ-027 mem_rd_wr, mem_addr and mem_wdata SHALL hold stable from ISSUE through DONE.
REQ-028 mem_valid SHALL be ignored in IDLE, ISSUE and DONE.
REQ-029 On a write, rdata SHALL still load mem_rdata at WAIT exit; requesters discard it.

Reset
REQ-030 reset_n low SHALL asynchronously force:
- state = IDLE, last_grant = 1 (so port 0 wins the first tie);
- ack = 0, busy = 0, mem_en = 0, mem_rd_wr = 0;
- mem_addr = 0, mem_wdata = 0, rdata = 0.
REQ-031 Reset asserted mid-transaction SHALL abandon it: no ack is issued, and the first post-reset request restarts at IDLE.

Structure
REQ-032 State encodings (IDLE=0, ISSUE=1, WAIT=2, DONE=3) and the port indices SHALL live in the shared memory-subsystem package.
REQ-033 Round-robin winner selection SHALL be one combinational sub-module, rr_pick2 (inputs req[1:0], last_grant; outputs a one-hot grant and a winner index).

Verification
REQ-034 Single read: req=01, rd_wr0=1, addr0=0x100; mem_valid after 3 cycles with rdata 0xA5..A5 -> mem_en in N+1, mem_addr=0x100, ack=01 with rdata=0xA5..A5 one cycle after mem_valid.
REQ-035 Tie from reset: req=11 -> port 0 granted first (ack=01); port 1 granted next (ack=10), last_grant=1 again.
REQ-036 Continuous contention: req=11 held for 4 transactions -> grant order 0,1,0,1, with no ack overlap.
REQ-037 Write: req=10, rd_wr1=0, wdata1=0xDEAD..BEEF -> mem_rd_wr=0, mem_wdata stable until DONE, ack=10.
REQ-038 Reset in WAIT: reset_n pulled low for 1 cycle -> all outputs 0 immediately; no ack; a subsequent req=01 completes normally.
REQ-039 Spurious mem_valid in IDLE, and req toggling during WAIT -> no state change and no effect on latched operands.
